// File: rtl/practice_doorlock.sv
// ============================================================================
// practice_doorlock
// ----------------------------------------------------------------------------
// Three-digit keypad door-lock controller. A press is registered on the first
// cycle a key appears after an all-keys-released cycle. Three consecutive
// presses form a code. After the third press, button_on goes high when the
// code matches FIRST_DIGIT, then SECOND_DIGIT_A or SECOND_DIGIT_B, then
// THIRD_DIGIT.
//
// Ports:
//   clock     in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-low reset
//   num       in  10  keypad, bit k high while key k is held (one-hot expected)
//   button_on out  1  registered unlock indicator (1 = last code accepted)
// ============================================================================
module practice_doorlock #(
    parameter int FIRST_DIGIT    = 5,
    parameter int SECOND_DIGIT_A = 2,
    parameter int SECOND_DIGIT_B = 7,
    parameter int THIRD_DIGIT    = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] num,
    output logic       button_on
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT1 = 2'd1,
        GOT2 = 2'd2
    } state_t;

    // Exact one-hot patterns for each accepted digit. Comparing the whole
    // vector against a single-bit mask rejects multi-key presses automatically,
    // so an invalid digit still counts as a press but can never match.
    localparam logic [9:0] MASK_FIRST    = 10'(1) << FIRST_DIGIT;
    localparam logic [9:0] MASK_SECOND_A = 10'(1) << SECOND_DIGIT_A;
    localparam logic [9:0] MASK_SECOND_B = 10'(1) << SECOND_DIGIT_B;
    localparam logic [9:0] MASK_THIRD    = 10'(1) << THIRD_DIGIT;

    state_t     r_state;
    logic [9:0] r_num_prev;
    logic       r_code_ok;
    logic       r_button_on;

    logic w_press;
    logic w_match_first;
    logic w_match_second;
    logic w_match_third;

    // Press only on the transition out of the all-released state; switching
    // directly between keys or holding a key produces no further presses.
    assign w_press        = (r_num_prev == 10'd0) && (num != 10'd0);
    assign w_match_first  = (num == MASK_FIRST);
    assign w_match_second = (num == MASK_SECOND_A) || (num == MASK_SECOND_B);
    assign w_match_third  = (num == MASK_THIRD);

    // A wrong digit never aborts entry: all three digits are always consumed,
    // so the correctness of individual digits is not revealed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_num_prev  <= 10'd0;
            r_code_ok   <= 1'b0;
            r_button_on <= 1'b0;
        end else begin
            r_num_prev <= num;
            if (w_press) begin
                case (r_state)
                    IDLE: begin
                        r_code_ok   <= w_match_first;
                        r_button_on <= 1'b0;
                        r_state     <= GOT1;
                    end
                    GOT1: begin
                        r_code_ok <= r_code_ok & w_match_second;
                        r_state   <= GOT2;
                    end
                    GOT2: begin
                        r_button_on <= r_code_ok & w_match_third;
                        r_state     <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign button_on = r_button_on;

endmodule

// File: tb/tb_practice_doorlock.sv
// ============================================================================
// tb_practice_doorlock
// ----------------------------------------------------------------------------
// Directed testbench for practice_doorlock. Inputs change on the falling
// clock edge; button_on is sampled on falling edges, i.e. half a cycle after
// the rising edge that samples each key press.
// ============================================================================
module tb_practice_doorlock;

    logic       clock;
    logic       reset;
    logic [9:0] num;
    logic       button_on;

    int total;
    int bad;

    practice_doorlock dut (
        .clock     (clock),
        .reset     (reset),
        .num       (num),
        .button_on (button_on)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [9:0] key(input int k);
        logic [9:0] one;
        one = 10'd1;
        return one << k;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge. Checks button_on right after the
    // sampling edge and again at the end of the release gap.
    task automatic press(input logic [9:0] mask, input int hold,
                         input logic exp, input string tag);
        num = mask;
        @(negedge clock);
        check({tag, "_edge"}, button_on, exp);
        $display("press %s num=%b button_on=%b", tag, mask, button_on);
        repeat (hold - 1) @(negedge clock);
        num = 10'd0;
        repeat (5) @(negedge clock);
        check({tag, "_gap"}, button_on, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        num   = 10'd0;
        #1;
        check("reset_state", button_on, 1'b0);
        #21;
        reset = 1'b1;
        @(negedge clock);
        check("after_reset", button_on, 1'b0);

        // 5-2-9 accepted
        press(key(5), 5, 1'b0, "c1_5");
        press(key(2), 5, 1'b0, "c1_2");
        press(key(9), 5, 1'b1, "c1_9");

        // 5-7-9: cleared by first press, then accepted
        press(key(5), 5, 1'b0, "c2_5");
        press(key(7), 5, 1'b0, "c2_7");
        press(key(9), 5, 1'b1, "c2_9");

        // 3-4-9 rejected
        press(key(3), 5, 1'b0, "c3_3");
        press(key(4), 5, 1'b0, "c3_4");
        press(key(9), 5, 1'b0, "c3_9");

        // 5-1-6 rejected
        press(key(5), 5, 1'b0, "c4_5");
        press(key(1), 5, 1'b0, "c4_1");
        press(key(6), 5, 1'b0, "c4_6");

        // Partial 5-2, then reset discards it
        press(key(5), 5, 1'b0, "c5_5");
        press(key(2), 5, 1'b0, "c5_2");
        reset = 1'b0;
        #1;
        check("mid_reset", button_on, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 5 held 20 cycles is one digit; code accepted
        press(key(5), 20, 1'b0, "c6_5long");
        press(key(2), 5, 1'b0, "c6_2");
        press(key(9), 5, 1'b1, "c6_9");

        // Two keys at once is an invalid first digit
        press(10'b10_0010_0000, 5, 1'b0, "c7_inv");
        press(key(2), 5, 1'b0, "c7_2");
        press(key(9), 5, 1'b0, "c7_9");

        // Switching 5 -> 3 without a release is still the single press 5
        num = key(5);
        @(negedge clock);
        check("c8_5_edge", button_on, 1'b0);
        repeat (2) @(negedge clock);
        num = key(3);
        repeat (3) @(negedge clock);
        check("c8_switch3", button_on, 1'b0);
        $display("press c8_5to3 num=%b button_on=%b", num, button_on);
        num = 10'd0;
        repeat (5) @(negedge clock);
        press(key(2), 5, 1'b0, "c8_2");
        press(key(9), 5, 1'b1, "c8_9");

        // Asynchronous reset between clock edges clears button_on at once
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", button_on, 1'b0);
        $display("async reset button_on=%b", button_on);
        #5;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_async_reset", button_on, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
